matrix_seq_ctrl: RTL and testbench
==================================

Name: matrix_seq_ctrl

Overview:
Loop sequencer for the matrix-multiply datapath. It runs three nested index counters (i = row of A/C, j = column of B/C, k = inner dimension) and drives the operand addresses, MAC clear/enable and result write strobe for one C = A x B job. Software starts a job with runtime dimensions through a start/done handshake. A downstream stall input can freeze the inner loop.

Parameters:
DIM_W, 4, width of each loop index; max supported dimension is 2**DIM_W
ADDR_W, 2*DIM_W, operand/result address width (derived; not overridden independently)

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  job request; sampled only in IDLE
dim_m  input  DIM_W+1  rows of A / C
dim_k  input  DIM_W+1  inner dimension
dim_n  input  DIM_W+1  columns of B / C
stall  input  1  datapath not ready; freezes MAC stepping
busy  output  1  job in progress
done  output  1  one-cycle job-complete pulse
err  output  1  valid with done; dimension illegal, no work done
a_addr  output  ADDR_W  {i,k}
b_addr  output  ADDR_W  {k,j}
c_addr  output  ADDR_W  {i,j}
mac_clear  output  1  clear accumulator
mac_en  output  1  accumulate current A/B operands
c_we  output  1  write accumulator to c_addr

Behaviour:
- Reset (reset=0, async): state IDLE, i=j=k=0. All outputs 0, including addresses. Latched dims = 0.
- States: IDLE, CLEAR, MAC, WRITE, DONE. All outputs are registered/decoded from state; none are combinational from start or dims.
- IDLE: busy=0. On start=1:
  - Latch dim_m/k/n and zero i, j, k.
  - If any dim is 0 or > 2**DIM_W, go to DONE with err latched 1.
  - Otherwise go to CLEAR with err=0.
- CLEAR: mac_clear=1 for exactly one cycle, k=0. Next state MAC. Not affected by stall.
- MAC: mac_en = !stall. Addresses reflect the current i, j, k.
  - stall=1: k holds, no state change.
  - stall=0 and k < dim_k-1: k increments.
  - stall=0 and k == dim_k-1: go to WRITE.
- WRITE: c_we=1 for one cycle with c_addr={i,j}. Not affected by stall. Then:
  - j < dim_n-1: j++, go to CLEAR.
  - Else if i < dim_m-1: j=0, i++, go to CLEAR.
  - Else: go to DONE.
- DONE: done=1 for one cycle, busy=0, err held valid. Always returns to IDLE. A start seen in DONE is ignored; it must be re-asserted in IDLE.
- busy=1 in CLEAR, MAC and WRITE only.
- start while busy: ignored; dims are not re-latched.
- Latency with no stalls: done is high in the cycle after edge number M*N*(K+2)+1, counted from the edge that sampled start. Each stall cycle in MAC adds exactly one cycle.
- Index wrap: counters never exceed dim-1. With dim == 2**DIM_W, the index reaches all-ones and the next transition resets it to 0.
- Reset mid-job: immediate return to IDLE. No done pulse, no further c_we.
- Address packing: index fields are DIM_W bits, row-major with a fixed stride of 2**DIM_W.

Optional Feature:
Macro MATRIX_SEQ_PERF_EN.
- Defined: adds output cycle_cnt [31:0].
  - Cleared to 0 on the accepted start.
  - Increments every cycle busy=1, stall cycles included.
  - Holds its value after done until the next accepted start.
  - Saturates at all-ones.
  - Reset value 0.
- Undefined: port and counter are absent. All other behaviour is identical.

Decomposition:
- Shared package/include matrix_pkg:
  - state encodings (IDLE=0, CLEAR=1, MAC=2, WRITE=3, DONE=4; 3-bit)
  - default DIM_W
  - ADDR_W derivation
- One natural sub-module, loop_idx_counter, instantiated three times (i, j, k):
  - inputs: clk, reset, clear, enable, limit
  - outputs: idx, last (idx == limit-1)
  - async active-low reset

Test Plan:
- Reset then start with M=K=N=2, no stall -> mac_clear pulses 4, mac_en high 8 cycles, c_we at c_addr 0x00, 0x01, 0x10, 0x11 in order, done on cycle 17 after start edge, err=0.
- M=1, K=3, N=1 with stall=1 held 2 cycles at k=1 -> b_addr sequence 0x00, 0x10 (held 2 cycles, mac_en=0), 0x20; done delayed by exactly 2 cycles versus the unstalled run.
- dim_k=0 (and separately dim_m=17 with DIM_W=4) -> no busy, no mac/c_we activity, done=1 with err=1 one cycle after start edge.
- M=K=N=16 with DIM_W=4 -> final c_we at c_addr 0xFF, indices never exceed 15, done after 16*16*18+1 edges.
- start pulsed during MAC and during DONE -> ignored, dims unchanged, exactly one done. Then reset=0 mid-MAC -> all outputs 0 immediately, no done.
- With MATRIX_SEQ_PERF_EN, M=K=N=2 plus 3 stall cycles -> cycle_cnt = 19 after done, held until the next start, then cleared to 0.

Source files
------------

// File: rtl/matrix_pkg.sv
// Shared definitions for the matrix-multiply loop sequencer: state encoding,
// default index width and the derived address width.
package matrix_pkg;

    localparam int DIM_W_DEFAULT = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_MAC   = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Address is {row_index, col_index}, each field DIM_W bits wide.
    function automatic int addr_w(input int dim_w);
        return 2 * dim_w;
    endfunction

endpackage

// File: rtl/loop_idx_counter.sv
// One loop index: counts 0..limit-1, wraps to 0 when stepped on its last value.
module loop_idx_counter
    import matrix_pkg::*;
#(
    parameter int DIM_W = DIM_W_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    input  logic [DIM_W:0]   limit,
    output logic [DIM_W-1:0] idx,
    output logic             last
);

    logic [DIM_W-1:0] idx_q, idx_d;

    // Compared at DIM_W+1 bits so a limit of 2**DIM_W ends at the all-ones index.
    assign last = ({1'b0, idx_q} == limit - 1'b1);
    assign idx  = idx_q;

    // NOTE: idx_d gets a default before any branch so no path leaves it unassigned (no latch).
    always_comb begin
        idx_d = idx_q;
        if (clear) begin
            idx_d = '0;
        end else if (enable) begin
            idx_d = last ? '0 : idx_q + 1'b1;
        end
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
        end
    end

endmodule

// File: rtl/matrix_seq_ctrl.sv
// Loop sequencer for one C = A x B job: walks i/j/k and strobes the MAC datapath.
// Define MATRIX_SEQ_PERF_EN to add the saturating busy-cycle counter output cycle_cnt.
module matrix_seq_ctrl
    import matrix_pkg::*;
#(
    parameter  int DIM_W  = DIM_W_DEFAULT,
    localparam int ADDR_W = addr_w(DIM_W)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DIM_W:0]    dim_m,
    input  logic [DIM_W:0]    dim_k,
    input  logic [DIM_W:0]    dim_n,
    input  logic              stall,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] a_addr,
    output logic [ADDR_W-1:0] b_addr,
    output logic [ADDR_W-1:0] c_addr,
    output logic              mac_clear,
    output logic              mac_en,
`ifdef MATRIX_SEQ_PERF_EN
    output logic              c_we,
    output logic [31:0]       cycle_cnt
`else
    output logic              c_we
`endif
);

    localparam logic [DIM_W:0] MAX_DIM = {1'b1, {DIM_W{1'b0}}};

    state_t           state_q, state_d;
    logic [DIM_W:0]   dim_m_q, dim_k_q, dim_n_q;
    logic             err_q;
    logic             accept;
    logic             bad_dims;
    logic [DIM_W-1:0] i_idx, j_idx, k_idx;
    logic             i_last, j_last, k_last;

    assign accept   = (state_q == ST_IDLE) && start;
    assign bad_dims = (dim_m == '0) || (dim_m > MAX_DIM) ||
                      (dim_k == '0) || (dim_k > MAX_DIM) ||
                      (dim_n == '0) || (dim_n > MAX_DIM);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            err_q   <= 1'b0;
            dim_m_q <= '0;
            dim_k_q <= '0;
            dim_n_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                err_q   <= bad_dims;
                dim_m_q <= dim_m;
                dim_k_q <= dim_k;
                dim_n_q <= dim_n;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        busy      = 1'b0;
        done      = 1'b0;
        mac_clear = 1'b0;
        mac_en    = 1'b0;
        c_we      = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) state_d = bad_dims ? ST_DONE : ST_CLEAR;
            end
            ST_CLEAR: begin
                busy      = 1'b1;
                mac_clear = 1'b1;
                state_d   = ST_MAC;
            end
            ST_MAC: begin
                busy   = 1'b1;
                mac_en = !stall;
                if (!stall && k_last) state_d = ST_WRITE;
            end
            ST_WRITE: begin
                busy    = 1'b1;
                c_we    = 1'b1;
                state_d = (i_last && j_last) ? ST_DONE : ST_CLEAR;
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Each counter wraps to 0 on its last value, so j rolls over exactly when i steps.
    loop_idx_counter #(.DIM_W(DIM_W)) u_i_cnt (
        .clk    (clk),
        .reset  (reset),
        .clear  (accept),
        .enable ((state_q == ST_WRITE) && j_last),
        .limit  (dim_m_q),
        .idx    (i_idx),
        .last   (i_last)
    );

    loop_idx_counter #(.DIM_W(DIM_W)) u_j_cnt (
        .clk    (clk),
        .reset  (reset),
        .clear  (accept),
        .enable (state_q == ST_WRITE),
        .limit  (dim_n_q),
        .idx    (j_idx),
        .last   (j_last)
    );

    loop_idx_counter #(.DIM_W(DIM_W)) u_k_cnt (
        .clk    (clk),
        .reset  (reset),
        .clear  (accept || (state_q == ST_CLEAR)),
        .enable ((state_q == ST_MAC) && !stall),
        .limit  (dim_k_q),
        .idx    (k_idx),
        .last   (k_last)
    );

    assign a_addr = {i_idx, k_idx};
    assign b_addr = {k_idx, j_idx};
    assign c_addr = {i_idx, j_idx};
    assign err    = err_q;

`ifdef MATRIX_SEQ_PERF_EN
    logic [31:0] cycle_cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycle_cnt_q <= '0;
        end else if (accept) begin
            cycle_cnt_q <= '0;
        end else if (busy && (cycle_cnt_q != '1)) begin
            cycle_cnt_q <= cycle_cnt_q + 32'd1;
        end
    end

    assign cycle_cnt = cycle_cnt_q;
`endif

endmodule

// File: tb/tb_matrix_seq_ctrl.sv
// Scoreboard bench for matrix_seq_ctrl: a job-schedule model predicts every strobe
// and its cycle; a negedge monitor pops and compares whenever the DUT strobes.
module tb_matrix_seq_ctrl;

    localparam int DIM_W = 4;
    localparam int AW    = 2 * DIM_W;
    localparam int MAXD  = 1 << DIM_W;

    localparam logic [3:0] K_CLEAR = 4'b0001;
    localparam logic [3:0] K_MAC   = 4'b0010;
    localparam logic [3:0] K_WRITE = 4'b0100;
    localparam logic [3:0] K_DONE  = 4'b1000;

    typedef struct {
        logic [3:0]    kind;
        int            cyc;
        logic [AW-1:0] a;
        logic [AW-1:0] b;
        logic [AW-1:0] c;
        logic          err;
    } ev_t;

    logic           clk   = 1'b0;
    logic           reset = 1'b1;
    logic           start = 1'b0;
    logic           stall = 1'b0;
    logic [DIM_W:0] dim_m = '0;
    logic [DIM_W:0] dim_k = '0;
    logic [DIM_W:0] dim_n = '0;
    logic           busy, done, err, mac_clear, mac_en, c_we;
    logic [AW-1:0]  a_addr, b_addr, c_addr;
`ifdef MATRIX_SEQ_PERF_EN
    logic [31:0]    cycle_cnt;
`endif

    int  cyc    = 0;
    int  checks = 0;
    int  errors = 0;
    ev_t exp_q[$];
    bit  pat[];
    int  force_stall[$];

    matrix_seq_ctrl #(.DIM_W(DIM_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .dim_m     (dim_m),
        .dim_k     (dim_k),
        .dim_n     (dim_n),
        .stall     (stall),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .a_addr    (a_addr),
        .b_addr    (b_addr),
        .c_addr    (c_addr),
        .mac_clear (mac_clear),
        .mac_en    (mac_en),
`ifdef MATRIX_SEQ_PERF_EN
        .c_we      (c_we),
        .cycle_cnt (cycle_cnt)
`else
        .c_we      (c_we)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    function automatic logic [63:0] pack(input logic [3:0] kind, input int c_no, input logic [AW-1:0] a,
                                         input logic [AW-1:0] b, input logic [AW-1:0] c,
                                         input logic bsy, input logic er);
        return {2'b00, kind, c_no, a, b, c, bsy, er};
    endfunction

    function automatic bit dims_bad(input int m, input int k, input int n);
        return (m == 0) || (m > MAXD) || (k == 0) || (k > MAXD) || (n == 0) || (n > MAXD);
    endfunction

    task automatic push_ev(input logic [3:0] kind, input int c_no, input int a, input int b,
                           input int c, input logic er);
        ev_t e;
        e.kind = kind;
        e.cyc  = c_no;
        e.a    = AW'(a);
        e.b    = AW'(b);
        e.c    = AW'(c);
        e.err  = er;
        exp_q.push_back(e);
    endtask

    // Schedule model: per output element one clear cycle, one MAC cycle per k
    // (pushed back by every stall cycle), one write cycle; done follows the last write.
    task automatic plan(input int m, input int k, input int n, input int s, output int t_done);
        int t = 0;
        if (dims_bad(m, k, n)) begin
            push_ev(K_DONE, s, 0, 0, 0, 1'b1);
            t_done = 0;
            return;
        end
        for (int i = 0; i < m; i++) begin
            for (int j = 0; j < n; j++) begin
                push_ev(K_CLEAR, s + t, 0, 0, 0, 1'b0);
                t++;
                for (int kk = 0; kk < k; kk++) begin
                    while (t < pat.size() && pat[t]) t++;
                    push_ev(K_MAC, s + t, i * MAXD + kk, kk * MAXD + j, 0, 1'b0);
                    t++;
                end
                push_ev(K_WRITE, s + t, 0, 0, i * MAXD + j, 1'b0);
                t++;
            end
        end
        push_ev(K_DONE, s + t, 0, 0, 0, 1'b0);
        t_done = t;
    endtask

    always @(negedge clk) begin
        logic [3:0] mask;
        ev_t        e;
        string      nm;
        if (reset) begin
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                e = exp_q.pop_front();
                check("missed_event", 64'(cyc), 64'(e.cyc));
            end
            mask = {done, c_we, mac_en, mac_clear};
            if (mask != 4'b0000) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_strobe", 64'(mask), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    case (e.kind)
                        K_CLEAR: nm = "clear";
                        K_MAC:   nm = "mac";
                        K_WRITE: nm = "write";
                        default: nm = "done";
                    endcase
                    check(nm,
                          pack(mask, cyc,
                               (e.kind == K_MAC)   ? a_addr : '0,
                               (e.kind == K_MAC)   ? b_addr : '0,
                               (e.kind == K_WRITE) ? c_addr : '0,
                               busy,
                               (e.kind == K_DONE)  ? err : 1'b0),
                          pack(e.kind, e.cyc, e.a, e.b, e.c, e.kind != K_DONE, e.err));
                end
            end
        end
    end

    task automatic check_reset_outputs();
        check("reset_outputs",
              64'({busy, done, err, mac_clear, mac_en, c_we, a_addr, b_addr, c_addr}), 64'd0);
`ifdef MATRIX_SEQ_PERF_EN
        check("reset_cycle_cnt", 64'(cycle_cnt), 64'd0);
`endif
    endtask

    // noisy: random start pulses and dim changes while the job runs, plus a start in DONE.
    task automatic run_job(input int m, input int k, input int n, input int stall_pct,
                           input bit noisy, input int reset_at);
        int s, t_done, len;
        @(posedge clk); #1;
        check("idle_busy", 64'(busy), 64'd0);
        len = m * n * (k + 2) * 3 + 16;
        pat = new[len];
        for (int x = 0; x < len; x++) pat[x] = ($urandom_range(0, 99) < stall_pct);
        foreach (force_stall[x]) if (force_stall[x] < len) pat[force_stall[x]] = 1'b1;
        force_stall.delete();
        s = cyc + 1;
        plan(m, k, n, s, t_done);
        start = 1'b1;
        dim_m = (DIM_W+1)'(m);
        dim_k = (DIM_W+1)'(k);
        dim_n = (DIM_W+1)'(n);
        for (int t = 0; t <= t_done; t++) begin
            @(posedge clk); #1;
            start = noisy && (t >= 1) && (($urandom_range(0, 3) == 0) || (t == t_done));
            if (noisy) begin
                dim_m = (DIM_W+1)'($urandom);
                dim_k = (DIM_W+1)'($urandom);
                dim_n = (DIM_W+1)'($urandom);
            end
            stall = (t < pat.size()) ? pat[t] : 1'b0;
`ifdef MATRIX_SEQ_PERF_EN
            if (reset_at < 0 && t == 0)      check("perf_cleared", 64'(cycle_cnt), 64'd0);
            if (reset_at < 0 && t == t_done) check("perf_final", 64'(cycle_cnt), 64'(t_done));
`endif
            if (t == reset_at) begin
                reset = 1'b0;
                exp_q.delete();
                #1;
                check_reset_outputs();
                break;
            end
        end
        start = 1'b0;
        stall = 1'b0;
        if (reset_at >= 0) begin
            repeat (3) @(negedge clk);
            reset = 1'b1;
        end else begin
            @(posedge clk); #1;
`ifdef MATRIX_SEQ_PERF_EN
            check("perf_hold", 64'(cycle_cnt), 64'(t_done));
`endif
        end
    endtask

    initial begin
        int m, k, n;
        #2 reset = 1'b0;
        #1 check_reset_outputs();
        repeat (2) @(negedge clk);
        reset = 1'b1;

        run_job(2, 2, 2, 0, 1'b0, -1);
        force_stall = '{2, 3};
        run_job(1, 3, 1, 0, 1'b0, -1);
        run_job(2, 0, 2, 0, 1'b0, -1);
        run_job(17, 1, 1, 0, 1'b0, -1);
        run_job(16, 16, 16, 0, 1'b0, -1);
        force_stall = '{1, 2, 3};
        run_job(2, 2, 2, 0, 1'b0, -1);
        run_job(2, 2, 2, 20, 1'b1, -1);

        for (int r = 0; r < 12; r++) begin
            m = $urandom_range(1, 5);
            k = $urandom_range(1, 5);
            n = $urandom_range(1, 5);
            case ($urandom_range(0, 7))
                0: k = 0;
                1: n = 17;
                2: m = 16;
                default: ;
            endcase
            run_job(m, k, n, 25, 1'($urandom_range(0, 1)), -1);
        end

        run_job(3, 4, 3, 0, 1'b0, 3);
        run_job(1, 1, 1, 0, 1'b0, -1);

        repeat (5) @(negedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
